// File: rtl/fifo_ptr_pkg.sv
// rtl/fifo_ptr_pkg.sv - pointer width helper and Gray/binary conversions shared by both FIFO pointer controllers
package fifo_ptr_pkg;

    localparam int MAX_PTR_W = 32;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Callers zero-extend narrower pointers and cast the result back, so one body serves every width up to MAX_PTR_W.
    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with asynchronous active-low reset to zero
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// rtl/fifo_wptr_ctrl.sv - write-domain pointer controller for a dual-clock FIFO
module fifo_wptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2,
    localparam int P           = ptr_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [P-1:0]          rptr_gray_async,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [P-1:0]          wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [P-1:0]          wr_level,
    output logic                  overflow
);

    localparam logic [P-1:0] AFULL_LVL = P'(AFULL_THRESH);

    logic [P-1:0] wbin;
    logic [P-1:0] wbin_next;
    logic [P-1:0] gray_next;
    logic [P-1:0] rsync2;
    logic [P-1:0] rbin;
    logic [P-1:0] level_next;
    logic         full_next;

    sync2 #(.WIDTH(P)) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rptr_gray_async),
        .q     (rsync2)
    );

    assign wr_en   = wr_req & ~full;
    assign wr_addr = wbin[ADDR_WIDTH-1:0];

    always_comb begin
        wbin_next  = wbin + P'(wr_en);
        gray_next  = P'(bin2gray(MAX_PTR_W'(wbin_next)));
        rbin       = P'(gray2bin(MAX_PTR_W'(rsync2)));
        level_next = wbin_next - rbin;
        // Full when the write pointer has lapped the read pointer: Gray form differs only in the top two bits.
        full_next  = (gray_next == {~rsync2[P-1:P-2], rsync2[P-3:0]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= gray_next;
            full        <= full_next;
            almost_full <= (level_next >= AFULL_LVL);
            wr_level    <= level_next;
            overflow    <= wr_req & full;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// tb/tb_fifo_wptr_ctrl.sv - scoreboard bench for fifo_wptr_ctrl with ADDR_WIDTH=4
module tb_fifo_wptr_ctrl;

    localparam int AW = 4;
    localparam int P  = AW + 1;
    localparam logic [P-1:0] AF = 5'd14;

    logic          clk;
    logic          rst_n;
    logic          wr_req;
    logic [P-1:0]  rptr_gray_async;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [P-1:0]  wptr_gray;
    logic          full;
    logic          almost_full;
    logic [P-1:0]  wr_level;
    logic          overflow;

    fifo_wptr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(14)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_req          (wr_req),
        .rptr_gray_async (rptr_gray_async),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .almost_full     (almost_full),
        .wr_level        (wr_level),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [P-1:0]  gray;
        logic          full;
        logic          af;
        logic [P-1:0]  level;
        logic          ovf;
        logic          acc;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    logic [P-1:0] m_wbin;
    logic [P-1:0] m_rs1;
    logic [P-1:0] m_rs2;
    logic         m_full;
    logic [P-1:0] prev_gray;
    logic [P-1:0] rp_cur;
    int           writes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wbin    = '0;
        m_rs1     = '0;
        m_rs2     = '0;
        m_full    = 1'b0;
        prev_gray = '0;
        sb.delete();
    endtask

    // rp is the read side's binary pointer; the bench drives its Gray form.
    task automatic cycle(input logic wr, input logic [P-1:0] rp);
        exp_t e;
        exp_t got;
        logic acc;
        @(negedge clk);
        wr_req          = wr;
        rptr_gray_async = rp ^ (rp >> 1);
        #1;
        acc = wr & ~m_full;
        check("wr_en", {31'd0, wr_en}, {31'd0, acc});
        if (acc) m_wbin = m_wbin + 5'd1;
        e.acc   = acc;
        e.addr  = m_wbin[AW-1:0];
        e.gray  = m_wbin ^ (m_wbin >> 1);
        e.level = m_wbin - m_rs2;
        e.full  = (e.level == 5'd16);
        e.af    = (e.level >= AF);
        e.ovf   = wr & m_full;
        m_rs2   = m_rs1;
        m_rs1   = rp;
        m_full  = e.full;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("wr_addr",     {28'd0, wr_addr},     {28'd0, got.addr});
        check("wptr_gray",   {27'd0, wptr_gray},   {27'd0, got.gray});
        check("full",        {31'd0, full},        {31'd0, got.full});
        check("almost_full", {31'd0, almost_full}, {31'd0, got.af});
        check("wr_level",    {27'd0, wr_level},    {27'd0, got.level});
        check("overflow",    {31'd0, overflow},    {31'd0, got.ovf});
        check("gray_step",   32'($countones(wptr_gray ^ prev_gray)), {31'd0, got.acc});
        prev_gray = wptr_gray;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  {28'd0, wr_addr},     32'd0);
        check({tag, "_gray"},  {27'd0, wptr_gray},   32'd0);
        check({tag, "_full"},  {31'd0, full},        32'd0);
        check({tag, "_af"},    {31'd0, almost_full}, 32'd0);
        check({tag, "_level"}, {27'd0, wr_level},    32'd0);
        check({tag, "_ovf"},   {31'd0, overflow},    32'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        wr_req          = 1'b0;
        rptr_gray_async = '0;
        model_reset();

        repeat (4) begin
            @(negedge clk);
            wr_req          = 1'($urandom_range(0, 1));
            rptr_gray_async = 5'($urandom_range(0, 31));
        end
        #1;
        check_all_zero("in_reset");
        @(negedge clk);
        wr_req          = 1'b0;
        rptr_gray_async = '0;
        rst_n           = 1'b1;
        #1;
        check_all_zero("post_reset");

        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, 5'd0);
            check("fill_af", {31'd0, almost_full}, {31'd0, (k >= 14)});
        end
        check("fill_full",  {31'd0, full},      32'd1);
        check("fill_level", {27'd0, wr_level},  32'd16);
        check("fill_gray",  {27'd0, wptr_gray}, 32'b11000);

        repeat (3) begin
            cycle(1'b1, 5'd0);
            check("ovf_pulse", {31'd0, overflow}, 32'd1);
            check("ovf_addr",  {28'd0, wr_addr},  32'd0);
        end
        cycle(1'b0, 5'd0);

        cycle(1'b0, 5'd1);
        check("drain_e1_full", {31'd0, full}, 32'd1);
        cycle(1'b0, 5'd1);
        check("drain_e2_full", {31'd0, full}, 32'd1);
        cycle(1'b0, 5'd1);
        check("drain_e3_full",  {31'd0, full},     32'd0);
        check("drain_e3_level", {27'd0, wr_level}, 32'd15);
        check("drain_addr",     {28'd0, wr_addr},  32'd0);
        cycle(1'b1, 5'd1);

        rp_cur = 5'd1;
        writes = 0;
        for (int it = 0; it < 400 && writes < 40; it++) begin
            logic w;
            w = ($urandom_range(0, 3) != 0);
            if (rp_cur != m_wbin && $urandom_range(0, 1) == 1) rp_cur = rp_cur + 5'd1;
            if (w && !m_full) writes++;
            cycle(w, rp_cur);
        end
        check("wrap_writes", writes, 40);

        for (int k = 0; k < 7; k++) begin
            rp_cur = m_wbin;
            cycle(1'b1, rp_cur);
        end
        #2;
        rst_n           = 1'b0;
        rptr_gray_async = '0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        wr_req = 1'b0;
        rst_n  = 1'b1;
        model_reset();
        #1;
        check("resume_addr", {28'd0, wr_addr}, 32'd0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 5'd0);
        check("resume_addr4", {28'd0, wr_addr}, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
